// File: rtl/ofdm_pkg.sv
// Shared types and default constants for the OFDM receive-path streaming blocks.
//   cplx_t  : packed complex sample {i, q} at the default sample width
//   state_t : symbol-framing states used by the CP remover
package ofdm_pkg;

  localparam int N_FFT_DEF  = 16;
  localparam int CP_MAX_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] i;
    logic signed [DATA_W_DEF-1:0] q;
  } cplx_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    SKIP     = 2'd1,
    PASS     = 2'd2
  } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-stage valid/ready output register carrying one complex sample plus
// first/last framing. Data is held stable while out_valid && !out_ready.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : upstream handshake (in_ready = !out_valid || out_ready)
//   in_i, in_q        : sample to register
//   in_first, in_last : framing flags travelling with the sample
//   out_*             : registered sample, flags and downstream handshake
module stream_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     out_first,
  output logic                     out_last
);

  logic                     vld_p1;
  logic signed [DATA_W-1:0] i_p1;
  logic signed [DATA_W-1:0] q_p1;
  logic                     first_p1;
  logic                     last_p1;

  assign in_ready = !vld_p1 || out_ready;

  // Stage p0 -> p1: capture on handshake, empty when drained with nothing new
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      i_p1     <= '0;
      q_p1     <= '0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        i_p1     <= in_i;
        q_p1     <= in_q;
        first_p1 <= in_first;
        last_p1  <= in_last;
      end else begin
        first_p1 <= 1'b0;
        last_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_i     = i_p1;
  assign out_q     = q_p1;
  assign out_first = first_p1;
  assign out_last  = last_p1;

endmodule

// File: rtl/cp_remove_stream.sv
// Streaming cyclic-prefix remover. Drops the first cp_len samples of each
// symbol and forwards the following N_FFT samples with first/last framing.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cp_len              : CP length, latched (clamped to CP_MAX) at symbol start
//   in_valid/in_ready   : input handshake; in_sof marks the first CP sample
//   in_i, in_q          : input complex sample
//   out_valid/out_ready : output handshake toward the FFT
//   out_i, out_q        : forwarded sample; out_first/out_last frame the symbol
//   sync_err            : one-cycle pulse when in_sof arrives mid-symbol
//   sym_cnt             : wrapping count of complete symbols emitted
module cp_remove_stream
  import ofdm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_FFT  = N_FFT_DEF,
  parameter int CP_MAX = CP_MAX_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(CP_MAX+1)-1:0]  cp_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic signed [DATA_W-1:0]     in_i,
  input  logic signed [DATA_W-1:0]     in_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W-1:0]     out_i,
  output logic signed [DATA_W-1:0]     out_q,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         sync_err,
  output logic [CNT_W-1:0]             sym_cnt
);

  localparam int CPL_W  = $clog2(CP_MAX+1);
  localparam int DCNT_W = $clog2(N_FFT);

  function automatic logic [CPL_W-1:0] clamp_cp(input logic [CPL_W-1:0] len);
    return (len > CPL_W'(CP_MAX)) ? CPL_W'(CP_MAX) : len;
  endfunction

  state_t              state_q, state_d;
  logic [CPL_W-1:0]    skip_cnt_q, skip_cnt_d;
  logic [CPL_W-1:0]    cpl_q, cpl_d;
  logic [DCNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic                sync_err_q, sync_err_d;

  logic [CPL_W-1:0]    cpl_new;
  logic [CPL_W-1:0]    skip_inc;
  logic                start_slot;
  logic                start_req;
  logic                fwd_req;
  logic                acc;
  logic                push;
  logic                push_ready;
  logic                push_first;
  logic                push_last;
  logic                err;

  assign cpl_new  = clamp_cp(cp_len);
  assign skip_inc = skip_cnt_q + 1'b1;

  // SKIP with skip_cnt = 0 marks "symbol start pending" after a full PASS:
  // the next sample starts a symbol whether or not it carries in_sof.
  assign start_slot = (state_q == SKIP) && (skip_cnt_q == '0);
  assign start_req  = (state_q == WAIT_SOF) ? in_sof : (in_sof || start_slot);

  // A sample is forwarded in PASS, or when it starts a symbol with zero CP.
  assign fwd_req    = start_req ? (cpl_new == '0) : (state_q == PASS);

  // Only samples headed for the output register can be back-pressured;
  // dropped samples are always accepted.
  assign in_ready   = fwd_req ? push_ready : 1'b1;
  assign acc        = in_valid && in_ready;
  assign push       = acc && fwd_req;
  assign push_first = start_req || (data_cnt_q == '0);
  assign push_last  = !start_req && (state_q == PASS) &&
                      (data_cnt_q == DCNT_W'(N_FFT-1));

  // in_sof on the would-be useful sample 0 (PASS, data_cnt = 0) or on the
  // pending-start slot is a clean symbol start, not an error.
  assign err = acc && in_sof &&
               (((state_q == SKIP) && (skip_cnt_q != '0)) ||
                ((state_q == PASS) && (data_cnt_q != '0)));

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    cpl_d      = cpl_q;
    data_cnt_d = data_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    sync_err_d = err;
    if (acc) begin
      if (start_req) begin
        cpl_d      = cpl_new;
        skip_cnt_d = '0;
        data_cnt_d = '0;
        if (cpl_new == '0) begin
          state_d    = PASS;
          data_cnt_d = DCNT_W'(1);
        end else if (cpl_new == CPL_W'(1)) begin
          state_d = PASS;
        end else begin
          state_d    = SKIP;
          skip_cnt_d = CPL_W'(1);
        end
      end else begin
        case (state_q)
          SKIP: begin
            if (skip_inc == cpl_q) begin
              state_d    = PASS;
              skip_cnt_d = '0;
              data_cnt_d = '0;
            end else begin
              skip_cnt_d = skip_inc;
            end
          end
          PASS: begin
            if (push_last) begin
              state_d    = SKIP;
              skip_cnt_d = '0;
              data_cnt_d = '0;
              sym_cnt_d  = sym_cnt_q + 1'b1;
            end else begin
              data_cnt_d = data_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Control state boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_SOF;
      skip_cnt_q <= '0;
      cpl_q      <= '0;
      data_cnt_q <= '0;
      sym_cnt_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      cpl_q      <= cpl_d;
      data_cnt_q <= data_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
  assign sym_cnt  = sym_cnt_q;

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (push_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .in_first  (push_first),
    .in_last   (push_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_first (out_first),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_cp_remove_stream.sv
module tb_cp_remove_stream;

  logic       clk;
  logic       rst;
  logic [2:0] cp_len;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [7:0] in_i;
  logic [7:0] in_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_i;
  logic [7:0] out_q;
  logic       out_first;
  logic       out_last;
  logic       sync_err;
  logic [15:0] sym_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_serr = 0;
  logic tog_en = 1'b0;
  logic [17:0] exp_q[$];

  cp_remove_stream #(
    .DATA_W (8),
    .N_FFT  (16),
    .CP_MAX (4),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cp_len    (cp_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_first (out_first),
    .out_last  (out_last),
    .sync_err  (sync_err),
    .sym_cnt   (sym_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] qval(input logic [7:0] v);
    return v ^ 8'hA5;
  endfunction

  // Output monitor: every valid output must match the scoreboard head, both
  // while stalled (hold) and when it is taken.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("out", 64'({out_i, out_q, out_first, out_last}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sync_err) n_serr++;
  end

  // out_ready pattern 1-0-0-1 when enabled
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic sof, input logic fwd,
                      input logic first, input logic last);
    logic done;
    in_valid = 1'b1;
    in_sof   = sof;
    in_i     = v;
    in_q     = qval(v);
    if (fwd) exp_q.push_back({v, qval(v), first, last});
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Symbol A with cp_len 3 (changed to 0 mid-symbol), then symbol B with no CP
  task automatic run_two(input logic [7:0] base);
    cp_len = 3'd3;
    for (int k = 0; k < 19; k++) begin
      if (k == 6) cp_len = 3'd0;
      send(base + 8'(k), k == 0, k >= 3, k == 3, k == 18);
    end
    for (int k = 0; k < 16; k++)
      send(base + 8'(19 + k), 1'b0, 1'b1, k == 0, k == 15);
  endtask

  initial begin
    rst = 1'b1; cp_len = 3'd0; in_valid = 1'b0; in_sof = 1'b0;
    in_i = '0; in_q = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_first_last", 64'({out_first, out_last}), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk("rst_sym_cnt", 64'(sym_cnt), 64'd0);
    chk("rst_out_data", 64'({out_i, out_q}), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic symbol: cp_len 3, samples 0..18
    cp_len = 3'd3;
    for (int k = 0; k < 19; k++)
      send(8'(k), k == 0, k >= 3, k == 3, k == 18);
    chk("s1_sym_cnt", 64'(sym_cnt), 64'd1);
    drain("s1");

    // Back-to-back symbols, cp_len change takes effect at next symbol
    run_two(8'd20);
    chk("s2_sym_cnt", 64'(sym_cnt), 64'd3);
    drain("s2");

    // Same stream under out_ready back-pressure
    tog_en = 1'b1;
    run_two(8'd60);
    chk("s3_sym_cnt", 64'(sym_cnt), 64'd5);
    drain("s3");
    tog_en = 1'b0;
    out_ready = 1'b1;
    idle(1);

    // Premature in_sof at useful sample 5
    cp_len = 3'd3;
    for (int k = 0; k < 8; k++)
      send(8'd100 + 8'(k), k == 0, k >= 3, k == 3, 1'b0);
    for (int k = 8; k < 11; k++)
      send(8'd100 + 8'(k), k == 8, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("s4_sync_err_cnt", 64'(n_serr), 64'd1);
    chk("s4_sym_cnt_hold", 64'(sym_cnt), 64'd5);
    for (int k = 11; k < 27; k++)
      send(8'd100 + 8'(k), 1'b0, 1'b1, k == 11, k == 26);
    chk("s4_sym_cnt", 64'(sym_cnt), 64'd6);
    drain("s4");
    chk("s4_sync_err_total", 64'(n_serr), 64'd1);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Pre-SOF junk dropped, cp_len 7 clamped to 4
    cp_len = 3'd7;
    for (int k = 0; k < 3; k++)
      send(8'd200 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      send(8'd203 + 8'(k), k == 0, k >= 4, k == 4, k == 19);
    chk("s5_sym_cnt", 64'(sym_cnt), 64'd1);
    drain("s5");

    // Reset mid-PASS with a stalled output
    cp_len = 3'd2;
    send(8'd230, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'd231, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++)
      send(8'd232 + 8'(k), 1'b0, 1'b1, k == 0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("s6_pre_valid", 64'(out_valid), 64'd1);
    chk("s6_stall_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(out_valid), 64'd0);
    chk("s6_rst_sym_cnt", 64'(sym_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cp_len = 3'd0;
    send(8'd245, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'd246, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("s6");
    chk("s6_sync_err_none", 64'(n_serr), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cp_remove_stream.md
Name: cp_remove_stream

Overview:
- Streaming, parametrised cyclic-prefix remover for the OFDM receive path.
- Accepts one complex sample (I, Q) per handshake.
- Discards the first cp_len samples of each symbol and forwards the next N_FFT samples to the FFT input with first/last framing.
- Generalises fixed-width CP stripping to run-time CP length, valid/ready flow control, resynchronisation and symbol counting.

Parameters:
- DATA_W, 8: bits per I and per Q sample.
- N_FFT, 16: useful samples per symbol; power of two, at least 4.
- CP_MAX, 4: largest supported CP length in samples; must be less than N_FFT.
- CNT_W, 16: width of the symbol counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cp_len  in  $clog2(CP_MAX+1)  CP length in samples; sampled only at symbol start
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_sof  in  1  marks the first sample (first CP sample) of a symbol
- in_i  in  DATA_W  input in-phase sample
- in_q  in  DATA_W  input quadrature sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream can accept a sample
- out_i  out  DATA_W  in-phase sample to FFT
- out_q  out  DATA_W  quadrature sample to FFT
- out_first  out  1  first useful sample of a symbol
- out_last  out  1  sample N_FFT-1 of a symbol
- sync_err  out  1  one-cycle pulse on a premature in_sof
- sym_cnt  out  CNT_W  number of complete symbols emitted; wraps

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - out_valid, out_first, out_last, sync_err = 0.
  - out_i, out_q = 0; sym_cnt = 0.
  - State = WAIT_SOF; counters = 0.
- Input acceptance: a sample is accepted when in_valid && in_ready. Inputs are don't-care when in_valid = 0.
- Output register: one registered stage, so latency is 1 cycle from acceptance to out_valid.
  - Output is held stable while out_valid && !out_ready.
- in_ready:
  - 1 in WAIT_SOF and SKIP (samples are dropped, never stalled).
  - In PASS: in_ready = !out_valid || out_ready.
- States:
  - WAIT_SOF: drop samples until an accepted sample has in_sof = 1.
  - SKIP: drop samples; count CP.
  - PASS: forward samples; count useful data.
- Symbol start (accepted sample with in_sof = 1, or the sample after a completed PASS):
  - Latch cpl = min(cp_len, CP_MAX).
  - If cpl = 0: this sample is useful sample 0; go to PASS.
  - Otherwise: it is CP sample 0; go to SKIP with skip_cnt = 1.
- SKIP:
  - Drop each accepted sample.
  - When skip_cnt reaches cpl, the next accepted sample enters PASS as useful sample 0.
- PASS:
  - Forward each accepted sample; increment data_cnt.
  - out_first = (data_cnt == 0); out_last = (data_cnt == N_FFT-1).
  - After sample N_FFT-1: sym_cnt increments and the state returns to symbol start. The next sample is the next symbol's CP, with or without in_sof.
- Premature in_sof (accepted while in SKIP, or in PASS with data_cnt != 0):
  - sync_err pulses for one cycle.
  - That sample starts a new symbol; cp_len is re-latched.
  - The truncated symbol emits no out_last; sym_cnt does not increment.
  - Samples already forwarded are not recalled.
- in_sof coincident with the sample that would be useful sample 0: treated as a new symbol start, not an error.
- cp_len changes mid-symbol have no effect until the next symbol start.
- sym_cnt wraps from 2^CNT_W-1 to 0.
- rst mid-symbol: all state clears immediately; a pending output is discarded; the block returns to WAIT_SOF.

Decomposition:
- Shared package ofdm_pkg holds:
  - typedef cplx_t {i, q} of DATA_W bits each;
  - state enum {WAIT_SOF, SKIP, PASS};
  - default constants N_FFT_DEF = 16, CP_MAX_DEF = 4, DATA_W_DEF = 8.
- One sub-module: stream_out_reg. It is the single-stage valid/ready output register carrying {i, q, first, last}, reusable by other OFDM streaming blocks.

Test Plan:
- Reset, then cp_len = 3, in_sof on sample 0, 19 consecutive samples with values 0..18, out_ready = 1 → outputs 3..18; out_first on 3, out_last on 18, sym_cnt = 1.
- Two back-to-back symbols: cp_len = 3 for the first, cp_len changed to 0 mid-first-symbol, in_sof only on the first sample → second symbol uses cpl = 0 and forwards all 16 samples; sym_cnt = 2.
- Same stream, out_ready toggling 1-0-0-1 → in_ready drops only in PASS; no sample is lost or duplicated; out_i/out_q held while stalled.
- in_sof reasserted at useful sample 5 → sync_err pulses once; no out_last for the aborted symbol; a new symbol drops 3 CP samples; sym_cnt unchanged until the next full symbol.
- cp_len = 7 (greater than CP_MAX) → exactly 4 samples dropped; samples arriving before the first in_sof after reset produce no output.
- rst asserted mid-PASS (data_cnt = 9) with out_valid = 1 → out_valid = 0 asynchronously, sym_cnt = 0, state WAIT_SOF.
